// File: rtl/mux8to1_pkg.sv
// Shared sizing constants for the triple-implementation 8:1 multiplexer.
package mux8to1_pkg;

   localparam int N_INPUTS = 8;
   localparam int SEL_W    = 3;

endpackage : mux8to1_pkg

// File: rtl/mux8to1_core_gate.sv
// Gate-level 8:1 single-bit multiplexer: sel decoded into minterms with NOT/AND
// primitives, each minterm gated with its data bit, products ORed together.
module mux8to1_core_gate
   import mux8to1_pkg::*;
(
   input  logic [N_INPUTS-1:0] d_i,
   input  logic [SEL_W-1:0]    sel_i,
   output logic                y_o
);

   logic [SEL_W-1:0]    sel_n;
   logic [N_INPUTS-1:0] minterm;
   logic [N_INPUTS-1:0] prod;

   not u_inv0 (sel_n[0], sel_i[0]);
   not u_inv1 (sel_n[1], sel_i[1]);
   not u_inv2 (sel_n[2], sel_i[2]);

   // minterm[i] is high exactly when sel == i (sel[2] is the MSB)
   and u_m0 (minterm[0], sel_n[2], sel_n[1], sel_n[0]);
   and u_m1 (minterm[1], sel_n[2], sel_n[1], sel_i[0]);
   and u_m2 (minterm[2], sel_n[2], sel_i[1], sel_n[0]);
   and u_m3 (minterm[3], sel_n[2], sel_i[1], sel_i[0]);
   and u_m4 (minterm[4], sel_i[2], sel_n[1], sel_n[0]);
   and u_m5 (minterm[5], sel_i[2], sel_n[1], sel_i[0]);
   and u_m6 (minterm[6], sel_i[2], sel_i[1], sel_n[0]);
   and u_m7 (minterm[7], sel_i[2], sel_i[1], sel_i[0]);

   and u_p0 (prod[0], minterm[0], d_i[0]);
   and u_p1 (prod[1], minterm[1], d_i[1]);
   and u_p2 (prod[2], minterm[2], d_i[2]);
   and u_p3 (prod[3], minterm[3], d_i[3]);
   and u_p4 (prod[4], minterm[4], d_i[4]);
   and u_p5 (prod[5], minterm[5], d_i[5]);
   and u_p6 (prod[6], minterm[6], d_i[6]);
   and u_p7 (prod[7], minterm[7], d_i[7]);

   or u_sum (y_o, prod[0], prod[1], prod[2], prod[3],
                  prod[4], prod[5], prod[6], prod[7]);

endmodule : mux8to1_core_gate

// File: rtl/mux8to1_triple.sv
// 8:1 mux built three ways (gate, dataflow, behavioural), cross-checked every
// clock with a sticky mismatch flag; y_q is the registered behavioural output.
module mux8to1_triple
   import mux8to1_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_INPUTS-1:0] d,
   input  logic [SEL_W-1:0]    sel,
   input  logic                clr_mismatch,
   output logic                y_gate,
   output logic                y_df,
   output logic                y_bm,
   output logic                y_q,
   output logic                mismatch
);

   logic y_bm_c;
   logic y_q_q, y_q_d;
   logic mismatch_q, mismatch_d;
   logic disagree;
   logic sel_unknown;

   mux8to1_core_gate u_gate (
      .d_i   (d),
      .sel_i (sel),
      .y_o   (y_gate)
   );

   assign y_df = sel[2] ? (sel[1] ? (sel[0] ? d[7] : d[6])
                                  : (sel[0] ? d[5] : d[4]))
                        : (sel[1] ? (sel[0] ? d[3] : d[2])
                                  : (sel[0] ? d[1] : d[0]));

   always_comb begin
      y_bm_c = d[0];
      case (sel)
         3'd0:    y_bm_c = d[0];
         3'd1:    y_bm_c = d[1];
         3'd2:    y_bm_c = d[2];
         3'd3:    y_bm_c = d[3];
         3'd4:    y_bm_c = d[4];
         3'd5:    y_bm_c = d[5];
         3'd6:    y_bm_c = d[6];
         3'd7:    y_bm_c = d[7];
         default: y_bm_c = d[0];
      endcase
   end

   assign y_bm = y_bm_c;

   // An unknown select makes the three forms legitimately differ in simulation,
   // so those cycles are not counted as disagreements.
`ifdef SYNTHESIS
   assign sel_unknown = 1'b0;
`else
   assign sel_unknown = ((^sel) === 1'bx);
`endif

   assign disagree = ((y_gate != y_df) || (y_df != y_bm)) && !sel_unknown;

   always_comb begin
      y_q_d      = y_bm;
      mismatch_d = mismatch_q | disagree;
      if (clr_mismatch) begin
         mismatch_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q_q      <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         y_q_q      <= y_q_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign y_q      = y_q_q;
   assign mismatch = mismatch_q;

endmodule : mux8to1_triple

// File: tb/tb_mux8to1_triple.sv
// Directed and random bench for mux8to1_triple: combinational agreement,
// register latency, asynchronous reset and sticky mismatch with clear.
module tb_mux8to1_triple;

   logic       clk;
   logic       rst_n;
   logic [7:0] d;
   logic [2:0] sel;
   logic       clr_mismatch;
   logic       y_gate, y_df, y_bm, y_q, mismatch;

   int n_checks = 0;
   int n_fail   = 0;
   logic [0:0] exp_q[$];

   mux8to1_triple dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .d            (d),
      .sel          (sel),
      .clr_mismatch (clr_mismatch),
      .y_gate       (y_gate),
      .y_df         (y_df),
      .y_bm         (y_bm),
      .y_q          (y_q),
      .mismatch     (mismatch)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive one vector on the falling edge, check the combinational outputs,
   // then check the register stage just after the next rising edge
   task automatic step(input logic [7:0] dv, input logic [2:0] sv, input string tag);
      logic       e;
      logic [0:0] ey;
      @(negedge clk);
      d   = dv;
      sel = sv;
      e   = dv[sv];
      #1;
      check({tag, "_gate"}, {31'd0, y_gate}, {31'd0, e});
      check({tag, "_df"},   {31'd0, y_df},   {31'd0, e});
      check({tag, "_bm"},   {31'd0, y_bm},   {31'd0, e});
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      ey = exp_q.pop_front();
      check({tag, "_yq"}, {31'd0, y_q}, {31'd0, ey});
      check({tag, "_mm"}, {31'd0, mismatch}, 32'd0);
   endtask

   logic [7:0] one_hot;
   logic [7:0] rd;
   logic [2:0] rs;

   initial begin
      rst_n        = 1'b0;
      d            = 8'h00;
      sel          = 3'd0;
      clr_mismatch = 1'b0;
      #2;
      check("reset_yq", {31'd0, y_q}, 32'd0);
      check("reset_mm", {31'd0, mismatch}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // alternating pattern: output equals sel[0]
      for (int s = 0; s < 8; s++) step(8'b10101010, 3'(s), "alt");

      // walking one across all selects
      for (int p = 0; p < 8; p++) begin
         one_hot = 8'd1 << p;
         for (int s = 0; s < 8; s++) step(one_hot, 3'(s), "walk");
      end

      // random pairs
      for (int i = 0; i < 1000; i++) begin
         rd = 8'($urandom_range(0, 255));
         rs = 3'($urandom_range(0, 7));
         step(rd, rs, "rand");
      end

      // forced disagreement sets the sticky flag
      @(negedge clk);
      d   = 8'hAA;
      sel = 3'd1;
      force dut.y_gate = 1'b0;
      @(posedge clk); #1;
      check("force_set", {31'd0, mismatch}, 32'd1);
      @(negedge clk);
      release dut.y_gate;
      @(posedge clk); #1;
      check("force_sticky", {31'd0, mismatch}, 32'd1);
      @(negedge clk);
      clr_mismatch = 1'b1;
      @(posedge clk); #1;
      check("clr", {31'd0, mismatch}, 32'd0);
      @(negedge clk);
      clr_mismatch = 1'b0;
      @(posedge clk); #1;
      check("clr_stays", {31'd0, mismatch}, 32'd0);

      // clear and disagreement on the same edge: clear wins, then re-sets
      @(negedge clk);
      force dut.y_gate = 1'b0;
      clr_mismatch = 1'b1;
      @(posedge clk); #1;
      check("clr_wins", {31'd0, mismatch}, 32'd0);
      @(negedge clk);
      clr_mismatch = 1'b0;
      @(posedge clk); #1;
      check("reset_after_clr", {31'd0, mismatch}, 32'd1);
      @(negedge clk);
      release dut.y_gate;

      // mid-cycle asynchronous reset with y_q = 1 and mismatch = 1
      d   = 8'hFF;
      sel = 3'd3;
      @(posedge clk); #1;
      check("pre_rst_yq", {31'd0, y_q}, 32'd1);
      check("pre_rst_mm", {31'd0, mismatch}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_yq", {31'd0, y_q}, 32'd0);
      check("async_rst_mm", {31'd0, mismatch}, 32'd0);
      check("rst_comb_bm", {31'd0, y_bm}, 32'd1);
      d = 8'b11110111;
      #1;
      check("rst_comb_gate", {31'd0, y_gate}, 32'd0);
      check("rst_comb_df", {31'd0, y_df}, 32'd0);
      @(posedge clk); #1;
      check("rst_hold_yq", {31'd0, y_q}, 32'd0);

      // release: first edge loads normally
      @(negedge clk);
      rst_n = 1'b1;
      d     = 8'b00001000;
      @(posedge clk); #1;
      check("release_yq", {31'd0, y_q}, 32'd1);
      check("release_mm", {31'd0, mismatch}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mux8to1_triple

// File: doc/mux8to1_triple.md
Name: mux8to1_triple

Overview:
- 8:1 single-bit multiplexer block built three ways in parallel: gate-level (AND/OR/NOT primitives), dataflow (continuous assign), and behavioural (case in combinational always).
- All three are compared every cycle and the result is registered with a sticky mismatch flag.
- Used as a cross-checked select primitive and as a reference for equivalence of coding styles.

Parameters:
- none (data width fixed at 1 bit per input, 8 inputs, 3-bit select)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- d  input  8  data inputs; d[i] is selected when sel == i
- sel  input  3  select, binary encoded, sel[2] MSB
- y_gate  output  1  combinational output of gate-level implementation
- y_df  output  1  combinational output of dataflow implementation
- y_bm  output  1  combinational output of behavioural implementation
- y_q  output  1  registered y_bm
- mismatch  output  1  sticky flag: set if the three combinational outputs ever disagreed at a clock edge
- clr_mismatch  input  1  synchronous clear of mismatch (placed after sel in port list)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Combinational path: y_gate = y_df = y_bm = d[sel] for all 256x8 input combinations, zero cycle latency, no clock dependence, unaffected by rst_n.
- Gate-level: decode sel into 8 minterms with NOT/AND primitives, AND each with d[i], OR the 8 products.
- Dataflow: single assign statement (nested conditional or sum-of-products).
- Behavioural: case on sel with a default branch driving d[0]; no latches.
- X handling: sel containing X/Z gives X on y_df/y_gate; behavioural follows simulator case semantics (default -> d[0]). Mismatch logic ignores cycles where sel has X/Z (uses ^sel === 1'bx guard in simulation only; synthesis sees plain compare).
- Register stage, posedge clk:
  - y_q <= y_bm.
  - mismatch <= 0 if clr_mismatch, else mismatch | (y_gate != y_df) | (y_df != y_bm).
  - Simultaneous clr_mismatch and new disagreement: clear wins for that edge; disagreement re-sets on the next edge if still present.
- Reset: rst_n low immediately forces y_q = 0 and mismatch = 0 regardless of clk; combinational outputs keep tracking d/sel during reset.
- Reset release: first active edge after rst_n rises loads normally.
- Latency: y_q is one clock behind y_bm.

Decomposition:
- Shared package mux8to1_pkg: localparams N_INPUTS = 8, SEL_W = 3.
- Natural sub-module: mux8to1_core_gate (the gate-level netlist) instantiated once.
- Dataflow and behavioural forms live inline in the top.
- Register and compare logic stay in the top.

Test Plan:
- d = 8'b10101010, sel stepped 000..111 with 10 time units each -> y_gate = y_df = y_bm = sel[0] (0,1,0,1,0,1,0,1); y_q follows one clock later; mismatch stays 0.
- d = 8'b00000001 and walking-one through all 8 positions, sel swept exhaustively (64 combos) -> all outputs are 1 only when sel equals the one-hot index.
- Exhaustive random: 1000 random d/sel pairs -> three outputs equal d[sel] every cycle; mismatch remains 0.
- Assert rst_n low mid-run with y_q = 1 -> y_q and mismatch drop to 0 immediately (before next clk edge); combinational outputs still valid.
- Force y_gate to an inverted value for one cycle (bench force) -> mismatch = 1 at the next edge and stays 1; pulse clr_mismatch with force released -> mismatch = 0 next edge.
- Apply clr_mismatch on the same edge as a forced disagreement -> mismatch = 0 that edge, 1 the following edge.
